// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing the register file's single read-mux port between N_REQ requesters.
// Each grant runs IDLE -> SEL -> ACK: latch address, let the mux settle a full cycle, return data.
module rf_read_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3,
   parameter int ID_W   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*ADDR_W-1:0]   raddr,
   output logic [ADDR_W-1:0]         rf_sel,
   input  logic [DATA_W-1:0]         rf_dout,
   output logic [N_REQ-1:0]          ack,
   output logic [DATA_W-1:0]         rdata,
   output logic [ID_W-1:0]           gnt_id,
   output logic                      busy
);

   // Handshake: a requester raises req[i] with raddr slice i and holds both until it sees
   // ack[i]=1 (rdata valid in that same cycle); req still high in the next IDLE is a new request.
   typedef enum logic [1:0] {IDLE, SEL, ACK} state_t;

   state_t          state, state_nxt;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] win;
   logic            win_vld;

   // Search starts at the round-robin pointer and wraps modulo N_REQ.
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!win_vld && req[(int'(ptr) + k) % N_REQ]) begin
            win_vld = 1'b1;
            win     = ID_W'((int'(ptr) + k) % N_REQ);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_vld) state_nxt = SEL;
         SEL:     state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_sel <= '0;
         rdata  <= '0;
         ack    <= '0;
         gnt_id <= '0;
         ptr    <= '0;
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  gnt_id <= win;
                  rf_sel <= raddr[int'(win)*ADDR_W +: ADDR_W];
               end
            end
            SEL: begin
               // The mux output has had the whole SEL cycle to settle from the registered select.
               rdata <= rf_dout;
               ack   <= N_REQ'(1) << gnt_id;
               ptr   <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter: a register-file mux model feeds rf_dout, and a scoreboard
// queue of {grant id, read data} is pushed when a request is driven and popped on each ack.
module tb_rf_read_arbiter;
   localparam int N_REQ  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 3;
   localparam int ID_W   = 2;
   localparam int W      = ID_W + DATA_W;

   logic                    clk;
   logic                    reset;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] raddr;
   logic [ADDR_W-1:0]       rf_sel;
   logic [DATA_W-1:0]       rf_dout;
   logic [N_REQ-1:0]        ack;
   logic [DATA_W-1:0]       rdata;
   logic [ID_W-1:0]         gnt_id;
   logic                    busy;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int waited;

   rf_read_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
      .clk(clk), .reset(reset), .req(req), .raddr(raddr), .rf_sel(rf_sel),
      .rf_dout(rf_dout), .ack(ack), .rdata(rdata), .gnt_id(gnt_id), .busy(busy)
   );

   // Register file contents: register n holds the nibble n replicated eight times.
   assign rf_dout = {8{1'b0, rf_sel}};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] reg_val(input logic [ADDR_W-1:0] a);
      return {8{1'b0, a}};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
   endtask

   task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
      raddr[i*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic push_exp(input int id, input logic [ADDR_W-1:0] a);
      exp_q.push_back({ID_W'(id), reg_val(a)});
   endtask

   task automatic wait_ack(input int bound, output int n);
      logic [W-1:0] e;
      bit got;
      got = 1'b0;
      n   = 0;
      while (!got && n < bound) begin
         tick();
         n++;
         if (ack != '0) got = 1'b1;
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $error("FAIL ack_timeout: observed no ack in %0d cycles, expected an ack", bound);
      end else if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL unexpected_ack: observed ack %b, expected none", ack);
      end else begin
         e = exp_q.pop_front();
         check("ack", 32'(ack), 32'(N_REQ'(1) << e[W-1 -: ID_W]));
         check("rdata", rdata, e[DATA_W-1:0]);
         check("gnt_id", 32'(gnt_id), 32'(e[W-1 -: ID_W]));
         check("busy_in_ack", 32'(busy), 32'd1);
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      raddr = '0;

      // Reset values
      tick();
      check("rst_rf_sel", 32'(rf_sel), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_gnt_id", 32'(gnt_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 32'd0);

      // Single request, reg 3
      req = 4'b0001;
      set_addr(0, 3'd3);
      push_exp(0, 3'd3);
      tick();
      check("single_rf_sel", 32'(rf_sel), 32'd3);
      check("single_busy_sel", 32'(busy), 32'd1);
      check("single_ack_sel", 32'(ack), 32'd0);
      wait_ack(6, waited);
      check("single_latency", 32'(waited + 1), 32'd2);
      req = '0;
      tick();
      check("single_idle_busy", 32'(busy), 32'd0);
      check("single_idle_ack", 32'(ack), 32'd0);
      check("single_hold_sel", 32'(rf_sel), 32'd3);
      check("single_hold_rdata", rdata, 32'h3333_3333);

      // All four after reset: grants 0,1,2,3
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req = 4'b1111;
      set_addr(0, 3'd1);
      set_addr(1, 3'd2);
      set_addr(2, 3'd5);
      set_addr(3, 3'd7);
      push_exp(0, 3'd1);
      push_exp(1, 3'd2);
      push_exp(2, 3'd5);
      push_exp(3, 3'd7);
      for (int g = 0; g < 4; g++) begin
         wait_ack(8, waited);
         check("all4_spacing", 32'(waited), (g == 0) ? 32'd2 : 32'd3);
         req = req & ~ack;
      end
      tick();

      // Grant 1, then 0011 -> 0, then 1 and 3 held -> 1 (pending), 3,1,3,1
      req = 4'b0010;
      set_addr(1, 3'd2);
      push_exp(1, 3'd2);
      wait_ack(6, waited);
      req = '0;
      tick();
      req = 4'b0011;
      set_addr(0, 3'd3);
      push_exp(0, 3'd3);
      wait_ack(6, waited);
      check("rr_after1_latency", 32'(waited), 32'd2);
      req = 4'b1010;
      set_addr(3, 3'd5);
      for (int g = 0; g < 5; g++) push_exp((g % 2 == 0) ? 1 : 3, (g % 2 == 0) ? 3'd2 : 3'd5);
      for (int g = 0; g < 5; g++) begin
         wait_ack(8, waited);
         check("rr_alt_spacing", 32'(waited), 32'd3);
      end
      req = '0;
      tick();

      // req[2] dropped during SEL
      req = 4'b0100;
      set_addr(2, 3'd6);
      push_exp(2, 3'd6);
      tick();
      check("drop_busy_sel", 32'(busy), 32'd1);
      check("drop_rf_sel", 32'(rf_sel), 32'd6);
      req = '0;
      wait_ack(6, waited);
      check("drop_latency", 32'(waited), 32'd1);
      tick();

      // Reset during SEL aborts, pending req[1] served after release
      req = 4'b0010;
      set_addr(1, 3'd4);
      tick();
      check("abort_rf_sel_pre", 32'(rf_sel), 32'd4);
      reset = 1'b1;
      #1;
      check("abort_rf_sel", 32'(rf_sel), 32'd0);
      check("abort_rdata", rdata, 32'd0);
      check("abort_gnt_id", 32'(gnt_id), 32'd0);
      check("abort_ack", 32'(ack), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      tick();
      check("abort_ack_held", 32'(ack), 32'd0);
      tick();
      check("abort_ack_held2", 32'(ack), 32'd0);
      reset = 1'b0;
      push_exp(1, 3'd4);
      wait_ack(6, waited);
      check("abort_resume_latency", 32'(waited), 32'd2);
      req = '0;
      tick();

      // Back-to-back from requester 0, raddr changed after first ack
      set_addr(0, 3'd2);
      req = 4'b0001;
      push_exp(0, 3'd2);
      wait_ack(6, waited);
      set_addr(0, 3'd7);
      push_exp(0, 3'd7);
      wait_ack(6, waited);
      check("b2b_spacing", 32'(waited), 32'd3);
      req = '0;
      tick();
      check("b2b_idle_busy", 32'(busy), 32'd0);
      check("b2b_hold_sel", 32'(rf_sel), 32'd7);
      check("b2b_hold_rdata", rdata, 32'h7777_7777);
      tick();
      check("final_ack", 32'(ack), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_read_arbiter.md
Name: rf_read_arbiter

Overview:
Round-robin arbiter that shares the single 8-to-1 read-mux port of the 8x32 register file between N_REQ requesters. It latches the winning requester's register address and drives the mux select from a register. It then captures the mux output and returns it with a one-cycle acknowledge. It sits between the requesters (shifter/counter control paths) and the register file's read mux.

Parameters:
N_REQ, 4, number of requesters (2..8); bench runs at 4
DATA_W, 32, read data width, equal to mux data width
ADDR_W, 3, register address width, equal to mux sel width
ID_W, 2, grant index width, ceil(log2(N_REQ))

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester read request, level, held until ack
raddr  input  N_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
rf_sel  output  ADDR_W  registered select to the register-file read mux
rf_dout  input  DATA_W  read-mux output (combinational from rf_sel)
ack  output  N_REQ  one-hot, one-cycle pulse; rdata valid while set
rdata  output  DATA_W  captured read data, held until next capture
gnt_id  output  ID_W  index of the current/last granted requester
busy  output  1  high when state != IDLE

Behaviour:
- Reset (async, immediate) drives the following values: state=IDLE, rf_sel=0, rdata=0, ack=0, gnt_id=0, rr pointer ptr=0, busy=0.
- FSM states: IDLE, SEL, ACK.
- IDLE: if req==0, stay. Otherwise pick the winner w, which is the first i with req[i]=1 searching ptr, ptr+1, ... mod N_REQ. On that edge the block loads gnt_id<=w, rf_sel<=raddr[w] and goes to SEL. raddr is sampled only on this edge.
- SEL: rf_sel is stable for the whole cycle. At its closing edge the block sets rdata<=rf_dout, ack<=one-hot(gnt_id), ptr<=(gnt_id+1) mod N_REQ, and goes to ACK.
- ACK: ack is high for exactly this cycle, then cleared, and the state goes to IDLE. req is not evaluated in ACK.
- Latency: the req-to-ack edge count is 2. A single requester gets ack in cycle 2 when req is seen in cycle 0. Peak throughput is 1 read per 3 cycles.
- Handshake: the requester holds req and raddr stable until it samples ack=1, then deasserts req on the next cycle. If req is still high in the following IDLE cycle, it is treated as a new request.
- req dropped during SEL: the transaction completes anyway, and ack and rdata are still issued.
- Simultaneous requests: exactly one winner per arbitration. The others keep waiting with no ack.
- Fairness: under continuous requests from all N_REQ requesters, grants rotate 0,1,2,3,0,... A requester waits at most N_REQ-1 grants.
- rf_sel and rdata hold their last values in IDLE; rf_sel does not return to 0.
- Reset asserted mid-transaction aborts it: no ack is issued and all outputs take their reset values while reset is high.
- ack never has more than one bit set, and is 0 in any state other than ACK.

Test Plan:
- Register-file model uses mux inputs a..h = 32'h0000_0000, 32'h1111_1111, ..., 32'h7777_7777.
- Single request: req=4'b0001, raddr[0]=3 at cycle 0 -> rf_sel=3 in cycle 1; ack=4'b0001 and rdata=32'h3333_3333 in cycle 2; busy high in cycles 1-2.
- All four request after reset with raddr = {7,5,2,1} (req3..req0), each dropping req after its ack -> grants in order 0,1,2,3 with rdata 1111_1111, 2222_2222, 5555_5555, 7777_7777; acks 3 cycles apart.
- Round robin: after a grant to 1, req=4'b0011 -> grant 0 next. Then with req 1 and 3 continuously asserted -> grants alternate 3,1,3,1.
- req[2] dropped during SEL with raddr[2]=6 -> ack[2] still pulses and rdata=32'h6666_6666.
- Reset asserted during SEL -> ack stays 0; rf_sel, rdata and gnt_id read 0 while reset is high. After release, a pending req[1] (raddr=4) is granted normally with rdata=32'h4444_4444.
- Back-to-back from one requester (req[0] held through the ACK cycle, raddr changed to 7 after ack) -> a second grant starts on the next IDLE edge and returns 32'h7777_7777.
